// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the fetch/data SRAM arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_DM = 2'd2} owner_t;
    localparam logic [3:0] BE_ALL = 4'hF;
    localparam int WORD_BYTES = 4;
endpackage

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: counts data wins over a waiting fetch; raises force_if at the limit.
module mem_arb_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic inc,
    input  logic clr,
    output logic force_if
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !force_if)
            cnt <= cnt + 1'b1;
    assign force_if = (cnt == CW'(STARVE_LIMIT));
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port SRAM between fetch and data ports,
// data-priority with a starvation guard, fixed one-cycle read response.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          if_req_i,
    input  logic [31:0]   if_addr_i,
    output logic          if_gnt_o,
    output logic          if_rvalid_o,
    output logic [31:0]   if_rdata_o,
    input  logic          dm_req_i,
    input  logic          dm_we_i,
    input  logic [3:0]    dm_be_i,
    input  logic [31:0]   dm_addr_i,
    input  logic [31:0]   dm_wdata_i,
    output logic          dm_gnt_o,
    output logic          dm_rvalid_o,
    output logic [31:0]   dm_rdata_o,
    output logic          sram_en_o,
    output logic          sram_we_o,
    output logic [3:0]    sram_be_o,
    output logic [AW-1:0] sram_addr_o,
    output logic [31:0]   sram_wdata_o,
    input  logic [31:0]   sram_rdata_i
);
    localparam int OFS = $clog2(WORD_BYTES);
    logic        dm_sel, if_sel, force_if, dm_wr;
    logic [31:0] if_hold, dm_hold;
    owner_t      owner;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{if_addr_i[31:AW+OFS], if_addr_i[OFS-1:0],
                                dm_addr_i[31:AW+OFS], dm_addr_i[OFS-1:0]};

    assign dm_sel   = dm_req_i && !force_if;
    assign if_sel   = if_req_i && !dm_sel;
    assign dm_gnt_o = dm_sel;
    assign if_gnt_o = if_sel;

    assign sram_en_o    = dm_sel || if_sel;
    assign sram_we_o    = dm_sel && dm_we_i;
    assign sram_be_o    = dm_sel ? (dm_we_i ? dm_be_i : BE_ALL) : (if_sel ? BE_ALL : 4'h0);
    assign sram_addr_o  = dm_sel ? dm_addr_i[AW+OFS-1:OFS] : (if_sel ? if_addr_i[AW+OFS-1:OFS] : '0);
    assign sram_wdata_o = dm_sel ? dm_wdata_i : '0;

    mem_arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .inc      (dm_sel && if_req_i),
        .clr      (if_sel || !if_req_i),
        .force_if (force_if)
    );

    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) begin
            owner   <= OWN_NONE;
            dm_wr   <= 1'b0;
            if_hold <= '0;
            dm_hold <= '0;
        end else begin
            owner   <= dm_sel ? OWN_DM : (if_sel ? OWN_IF : OWN_NONE);
            dm_wr   <= dm_sel && dm_we_i;
            if_hold <= if_rdata_o;
            dm_hold <= dm_rdata_o;
        end

    // Read data passes straight through in the response cycle, then is held.
    assign if_rvalid_o = (owner == OWN_IF);
    assign dm_rvalid_o = (owner == OWN_DM);
    assign if_rdata_o  = if_rvalid_o ? sram_rdata_i : if_hold;
    assign dm_rdata_o  = (dm_rvalid_o && !dm_wr) ? sram_rdata_i : dm_hold;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against
// a transaction-level model with a byte-addressed shadow memory.
module tb_mem_port_arbiter;
    localparam int AW    = 10;
    localparam int LIMIT = 4;
    localparam int DEPTH = 1 << AW;
    localparam logic [31:0] MASK = 32'hFFFF_F03F;

    logic          clk = 1'b0, rstn_i = 1'b0;
    logic          if_req_i = 1'b0, dm_req_i = 1'b0, dm_we_i = 1'b0;
    logic [31:0]   if_addr_i = '0, dm_addr_i = '0, dm_wdata_i = '0;
    logic [3:0]    dm_be_i = '0;
    logic          if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o, sram_en_o, sram_we_o;
    logic [31:0]   if_rdata_o, dm_rdata_o, sram_wdata_o;
    logic [31:0]   sram_rdata_i = '0;
    logic [3:0]    sram_be_o;
    logic [AW-1:0] sram_addr_o;

    int passed = 0, total = 0;

    mem_port_arbiter #(.AW(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk), .rstn_i(rstn_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o),
        .dm_rdata_o(dm_rdata_o), .sram_en_o(sram_en_o), .sram_we_o(sram_we_o),
        .sram_be_o(sram_be_o), .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o),
        .sram_rdata_i(sram_rdata_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        if (i == 4) return 32'hDEADBEEF;
        if (i == 8) return 32'h11223344;
        if (i < 3) return 32'hA0A0_0000 + i;
        return i * 32'h9E3779B9 ^ 32'h5A5A_1234;
    endfunction

    function automatic int word_of(logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        else passed++;
    endtask

    // SRAM macro model: writes land at the grant edge, reads return one cycle later.
    logic [31:0] sram [DEPTH];
    logic        sinit = 1'b0;
    always @(posedge clk) begin
        if (!sinit) begin
            for (int i = 0; i < DEPTH; i++) sram[i] <= init_word(i);
            sinit <= 1'b1;
        end else if (sram_en_o) begin
            if (sram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be_o[b]) sram[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
            end else
                sram_rdata_i <= sram[sram_addr_o];
        end
    end

    // Reference model: shadow memory, starvation tally, pending responses.
    logic [31:0] ref_mem [DEPTH];
    logic        minit = 1'b0;
    int          wait_cnt;
    logic        e_if_rv, e_dm_rv, g_if, g_dm;
    logic [31:0] e_if_rd, e_dm_rd;
    int          w;
    always @(negedge clk) begin
        if (!minit) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
            minit = 1'b1;
        end
        if (!rstn_i) begin
            chk("rst_if_rvalid", 32'(if_rvalid_o), 0);
            chk("rst_dm_rvalid", 32'(dm_rvalid_o), 0);
            chk("rst_if_rdata", if_rdata_o, 0);
            chk("rst_dm_rdata", dm_rdata_o, 0);
            chk("rst_sram_en", 32'(sram_en_o), 0);
            wait_cnt = 0; e_if_rv = 0; e_dm_rv = 0; e_if_rd = '0; e_dm_rd = '0;
        end else begin
            g_dm = dm_req_i && (wait_cnt < LIMIT);
            g_if = if_req_i && !g_dm;
            w = g_dm ? word_of(dm_addr_i) : word_of(if_addr_i);
            chk("dm_gnt", 32'(dm_gnt_o), 32'(g_dm));
            chk("if_gnt", 32'(if_gnt_o), 32'(g_if));
            chk("sram_en", 32'(sram_en_o), 32'(g_dm || g_if));
            chk("sram_we", 32'(sram_we_o), 32'(g_dm && dm_we_i));
            chk("sram_be", 32'(sram_be_o), (g_dm && dm_we_i) ? 32'(dm_be_i) : (g_dm || g_if) ? 32'hF : 0);
            chk("sram_addr", 32'(sram_addr_o), (g_dm || g_if) ? 32'(w) : 0);
            if (!g_if) chk("sram_wdata", sram_wdata_o, g_dm ? dm_wdata_i : 0);
            chk("if_rvalid", 32'(if_rvalid_o), 32'(e_if_rv));
            chk("dm_rvalid", 32'(dm_rvalid_o), 32'(e_dm_rv));
            chk("if_rdata", if_rdata_o, e_if_rd);
            chk("dm_rdata", dm_rdata_o, e_dm_rd);
            if (!if_req_i || g_if) wait_cnt = 0;
            else if (g_dm && wait_cnt < LIMIT) wait_cnt++;
            e_if_rv = g_if;
            e_dm_rv = g_dm;
            if (g_if) e_if_rd = ref_mem[w];
            if (g_dm && !dm_we_i) e_dm_rd = ref_mem[w];
            if (g_dm && dm_we_i)
                for (int b = 0; b < 4; b++)
                    if (dm_be_i[b]) ref_mem[w][8*b +: 8] = dm_wdata_i[8*b +: 8];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic ig, dg;
    initial begin
        repeat (2) @(posedge clk);
        #1 rstn_i = 1'b1;
        repeat (3) step();
        // Single fetch from word 4
        if_req_i = 1'b1; if_addr_i = 32'h10;
        @(negedge clk);
        chk("fetch_gnt", 32'(if_gnt_o), 1);
        chk("fetch_addr", 32'(sram_addr_o), 4);
        step(); if_req_i = 1'b0;
        @(negedge clk);
        chk("fetch_rvalid", 32'(if_rvalid_o), 1);
        chk("fetch_rdata", if_rdata_o, 32'hDEADBEEF);
        // Byte store to lane 2 of word 8, then full-word load
        step(); dm_req_i = 1'b1; dm_we_i = 1'b1; dm_be_i = 4'b0100; dm_addr_i = 32'h22; dm_wdata_i = 32'h00AB0000;
        @(negedge clk);
        chk("store_gnt", 32'(dm_gnt_o), 1);
        chk("store_be", 32'(sram_be_o), 4);
        chk("store_addr", 32'(sram_addr_o), 8);
        step(); dm_req_i = 1'b0; dm_we_i = 1'b0;
        @(negedge clk);
        chk("store_ack", 32'(dm_rvalid_o), 1);
        chk("store_rdata_held", dm_rdata_o, 0);
        step(); dm_req_i = 1'b1; dm_be_i = 4'h0; dm_addr_i = 32'h20;
        @(negedge clk);
        chk("load_be", 32'(sram_be_o), 32'hF);
        step(); dm_req_i = 1'b0;
        @(negedge clk);
        chk("load_rdata", dm_rdata_o, 32'h11AB3344);
        // Address wrap modulo depth
        step(); if_req_i = 1'b1; if_addr_i = 32'h1004;
        @(negedge clk);
        chk("wrap_addr", 32'(sram_addr_o), 1);
        step(); if_req_i = 1'b0;
        // Back-to-back fetches
        for (int i = 0; i < 5; i++) begin
            step();
            if_req_i = (i < 3);
            if_addr_i = 32'(4 * i);
            @(negedge clk);
            if (i < 3) chk("pipe_gnt", 32'(if_gnt_o), 1);
            if (i >= 1 && i <= 3) begin
                chk("pipe_rvalid", 32'(if_rvalid_o), 1);
                chk("pipe_rdata", if_rdata_o, 32'hA0A0_0000 + 32'(i - 1));
            end
        end
        // Contention: DM x4 then IF, repeating
        step(); if_req_i = 1'b1; if_addr_i = 32'h40; dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h44;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("contend_seq", 32'({dm_gnt_o, if_gnt_o}), (i % 5 == 4) ? 32'b01 : 32'b10);
            step();
        end
        if_req_i = 1'b0; dm_req_i = 1'b0;
        // Random traffic, each requester holds until granted
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            ig = if_gnt_o; dg = dm_gnt_o;
            step();
            if (!if_req_i || ig) begin
                if_req_i = ($urandom_range(0, 3) != 0);
                if_addr_i = $urandom & MASK;
            end
            if (!dm_req_i || dg) begin
                dm_req_i = ($urandom_range(0, 2) != 0);
                dm_we_i = 1'($urandom_range(0, 1));
                dm_be_i = 4'($urandom);
                dm_addr_i = $urandom & MASK;
                dm_wdata_i = $urandom;
            end
        end
        step(); if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0;
        // Reset while a fetch response is in flight
        step(); if_req_i = 1'b1; if_addr_i = 32'h10;
        @(negedge clk);
        step(); if_req_i = 1'b0;
        #2 rstn_i = 1'b0;
        #1 chk("midrst_rvalid", 32'(if_rvalid_o), 0);
        @(negedge clk);
        step(); rstn_i = 1'b1;
        @(negedge clk);
        chk("postrst_rvalid", 32'(if_rvalid_o), 0);
        step();
        @(negedge clk);
        chk("postrst_rvalid2", 32'(if_rvalid_o), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port, word-wide unified SRAM between the core's instruction-fetch port and its load/store (data) port. Each port uses a request/grant handshake with a fixed one-cycle read response. Data accesses have priority; a starvation counter guarantees forward progress for fetch. The block sits between the pipeline's IF/MEM stages and the SRAM macro, replacing direct flattened-memory indexing.

Parameters:
AW, 10, SRAM word-address width (depth = 2**AW words)
STARVE_LIMIT, 4, consecutive data grants with fetch waiting before fetch is forced to win (>=1)

Ports:
clk_i  in  1  clock; all state updates on rising edge
rstn_i  in  1  reset, asynchronous, active-low
if_req_i  in  1  fetch request; held with if_addr_i until if_gnt_o
if_addr_i  in  32  fetch byte address
if_gnt_o  out  1  fetch granted this cycle
if_rvalid_o  out  1  fetch read data valid
if_rdata_o  out  32  fetch read data
dm_req_i  in  1  data request; held with dm_* until dm_gnt_o
dm_we_i  in  1  1 = write, 0 = read
dm_be_i  in  4  byte enables; bit n enables byte lane n
dm_addr_i  in  32  data byte address
dm_wdata_i  in  32  write data, lane-aligned
dm_gnt_o  out  1  data granted this cycle
dm_rvalid_o  out  1  data response (read data or write ack)
dm_rdata_o  out  32  data read data
sram_en_o  out  1  SRAM access strobe
sram_we_o  out  1  SRAM write
sram_be_o  out  4  SRAM byte enables
sram_addr_o  out  AW  SRAM word address
sram_wdata_o  out  32  SRAM write data
sram_rdata_i  in  32  SRAM read data, valid one cycle after en

Behaviour:
- Reset (async assert, sync deassert to clk_i): owner=NONE, starve_cnt=0, if_rvalid_o=dm_rvalid_o=0, if_rdata_o=dm_rdata_o=0. Grants and SRAM strobes are combinational and 0 while no request is present.
- Arbitration (combinational, one grant per cycle): force_if = (starve_cnt == STARVE_LIMIT). If dm_req_i && !force_if, grant data. Otherwise, if if_req_i, grant fetch. Otherwise, no grant.
- Grant cycle drives sram_en_o=1 and sram_addr_o = granted addr[AW+1:2]. Address bits [1:0] and bits above AW+1 are ignored; wrap-around is modulo depth.
- Fetch grant: sram_we_o=0, sram_be_o=4'hF. Data grant: sram_we_o=dm_we_i, sram_be_o=dm_be_i (forced 4'hF on reads), sram_wdata_o=dm_wdata_i.
- No grant: sram_en_o=0, sram_we_o=0, sram_be_o=0, sram_addr_o and sram_wdata_o = 0.
- Response: owner register records the granted port (NONE/IF/DM) at every edge. In the cycle after a grant, the owner's rvalid is 1 for exactly one cycle. Read: rdata = sram_rdata_i, registered into the port's rdata output. Data write: dm_rvalid_o=1, and dm_rdata_o keeps its previous value. Latency is fixed at 1 cycle. Back-to-back grants are fully pipelined (throughput 1/cycle).
- rdata outputs hold their last value between responses; the non-owner port's rvalid is 0.
- Starvation counter:
  - Increments when a data grant occurs while if_req_i=1 (saturates at STARVE_LIMIT).
  - Clears to 0 on any fetch grant, or in any cycle with if_req_i=0.
  - On force_if the data request waits; dm_gnt_o=0 that cycle.
- Simultaneous requests without force: data wins, and fetch waits with if_gnt_o=0.
- Reset mid-transaction: the in-flight response is dropped (no rvalid after reset release). Requesters must re-issue.
- Writes reach the SRAM in the grant cycle. A data read granted the following cycle to the same word returns the new data; no bypass logic is required.

Decomposition:
- Package mem_arb_pkg: owner enum (OWN_NONE, OWN_IF, OWN_DM), BE_ALL=4'hF, WORD_BYTES=4.
- Sub-module mem_arb_starve_ctr: the saturating counter, with inputs inc/clr and output force. It is parameterized by STARVE_LIMIT.
- Grant mux, owner register and response registers stay in the top.

Test Plan:
- After reset: all outputs 0, and no rvalid for 3 idle cycles. Assert rstn_i low mid-cycle with a fetch in flight: if_rvalid_o stays 0 after release.
- Fetch only: if_req_i=1, if_addr_i=0x0000_0010, SRAM word 4 = 0xDEADBEEF → if_gnt_o=1, sram_addr_o=4 same cycle; next cycle if_rvalid_o=1, if_rdata_o=0xDEADBEEF.
- Byte store then load: dm_we_i=1, dm_be_i=4'b0100, dm_addr_i=0x22, wdata=0x00AB0000 → sram_be_o=4'b0100, addr=8; next cycle dm_rvalid_o=1. Read at 0x20 returns byte 2 = 0xAB, with other bytes unchanged.
- Contention: both request every cycle with STARVE_LIMIT=4 → grant sequence DM,DM,DM,DM,IF, repeating; no port idle longer than 4 cycles.
- Pipelining: fetch at 0x0, 0x4, 0x8 on consecutive cycles, no data traffic → three grants, then three consecutive if_rvalid_o pulses with words 0, 1, 2 in order.
- Wrap: if_addr_i=0x0000_1004 with AW=10 → sram_addr_o=1.
